// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID pipeline register and its fetch-address checker.
// Fetch-fault detection is compiled in only when IF_ID_FETCH_EXC_EN is defined.
package if_id_reg_pkg;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
endpackage

// File: rtl/if_id_reg_fetch_exc_chk.sv
// Combinational fetch-address checker: flags misaligned PCs and PCs outside
// the instruction memory window [IM_LO, IM_HI].
module fetch_exc_chk
  import if_id_reg_pkg::*;
(
  input  logic [31:0] PcF,
  output logic        fault
);
  always_comb begin
    fault = 1'b0;
    if ((PcF[1:0] != 2'b00) || (PcF < IM_LO) || (PcF > IM_HI)) fault = 1'b1;
  end
endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (CP0Req|EXLclr) > stall > load.
// Define IF_ID_FETCH_EXC_EN to tag faulting fetch PCs with AdEL.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        CP0Req,
  input  logic        EXLclr,
  input  logic        isBJD,
  input  logic [31:0] InstrF,
  input  logic [31:0] PcF,
  output logic [31:0] InstrD,
  output logic [31:0] PcD,
  output logic [4:0]  ExcCodeD,
  output logic        BDD,
  output logic        ValidD
);
  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [4:0]  exc_d, exc_q;
  logic        bd_d, bd_q;
  logic        valid_d, valid_q;
  logic        fault;
  logic        flush;

`ifdef IF_ID_FETCH_EXC_EN
  fetch_exc_chk u_chk (
    .PcF   (PcF),
    .fault (fault)
  );
`else
  assign fault = 1'b0;
`endif

  assign flush = CP0Req | EXLclr;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (flush) begin
      // PC is kept so the bubble still carries a meaningful address
      instr_d = INSTR_NOP;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = fault ? INSTR_NOP : InstrF;
      exc_d   = fault ? EXC_ADEL : EXC_NONE;
      pc_d    = PcF;
      bd_d    = isBJD;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= INSTR_NOP;
      pc_q    <= PC_RESET;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PcD      = pc_q;
  assign ExcCodeD = exc_q;
  assign BDD      = bd_q;
  assign ValidD   = valid_q;
endmodule

// File: tb/tb_if_id_reg.sv
// Directed vector table plus randomized run against a behavioural model of
// the IF/ID register; expectations follow IF_ID_FETCH_EXC_EN when defined.
module tb_if_id_reg;
`ifdef IF_ID_FETCH_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, CP0Req = 1'b0, EXLclr = 1'b0, isBJD = 1'b0;
  logic [31:0] InstrF = 32'h0, PcF = 32'h3000;
  logic [31:0] InstrD, PcD;
  logic [4:0]  ExcCodeD;
  logic        BDD, ValidD;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_instr, m_pc;
  logic [4:0]  m_exc;
  logic        m_bd, m_v;

  typedef struct {
    logic        rst, stl, cp0, exl, bjd;
    logic [31:0] instr, pc;
    logic [31:0] e_instr, e_pc;
    logic [4:0]  e_exc;
    logic        e_bd, e_v;
  } vec_t;

  vec_t tbl[16];

  if_id_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .CP0Req(CP0Req), .EXLclr(EXLclr),
    .isBJD(isBJD), .InstrF(InstrF), .PcF(PcF), .InstrD(InstrD), .PcD(PcD),
    .ExcCodeD(ExcCodeD), .BDD(BDD), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  function automatic bit ref_fault(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
  endfunction

  function automatic vec_t mk(input logic r, s, c, e, b, input logic [31:0] i, p,
                              input logic [31:0] ei, ep, input logic [4:0] ee,
                              input logic eb, ev);
    vec_t v;
    v.rst = r; v.stl = s; v.cp0 = c; v.exl = e; v.bjd = b; v.instr = i; v.pc = p;
    v.e_instr = ei; v.e_pc = ep; v.e_exc = ee; v.e_bd = eb; v.e_v = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance one edge, update the model.
  task automatic apply(input logic r, s, c, e, b, input logic [31:0] i, p);
    bit f;
    reset = r; stall = s; CP0Req = c; EXLclr = e; isBJD = b; InstrF = i; PcF = p;
    @(posedge clk);
    #1;
    if (r) begin
      m_instr = 32'h0; m_pc = 32'h3000; m_exc = 5'd0; m_bd = 1'b0; m_v = 1'b0;
    end else if (c || e) begin
      m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_v = 1'b0;
    end else if (!s) begin
      f = EXC_EN && ref_fault(p);
      m_instr = f ? 32'h0 : i;
      m_exc   = f ? 5'd4 : 5'd0;
      m_pc    = p; m_bd = b; m_v = 1'b1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".InstrD"},   InstrD,          m_instr);
    chk({tag, ".PcD"},      PcD,             m_pc);
    chk({tag, ".ExcCodeD"}, {27'h0, ExcCodeD}, {27'h0, m_exc});
    chk({tag, ".BDD"},      {31'h0, BDD},    {31'h0, m_bd});
    chk({tag, ".ValidD"},   {31'h0, ValidD}, {31'h0, m_v});
  endtask

  initial begin
    logic [4:0] fe;
    logic [31:0] pc_r;
    int sel;
    fe = EXC_EN ? 5'd4 : 5'd0;
    //         rst stl cp0 exl bjd instr          pc              e_instr                          e_pc           exc  bd  v
    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h3000, 32'h0,                            32'h3000, 5'd0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h2408_0001, 32'h3000, 32'h2408_0001,                   32'h3000, 5'd0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h1111_1111, 32'h3004, 32'h1111_1111,                   32'h3004, 5'd0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 1, 32'hAAAA_0001, 32'h3008, 32'h1111_1111,                   32'h3004, 5'd0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 0, 0, 32'hAAAA_0002, 32'h300C, 32'h1111_1111,                   32'h3004, 5'd0, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, 1, 32'hAAAA_0003, 32'h3010, 32'h1111_1111,                   32'h3004, 5'd0, 0, 1);
    tbl[6]  = mk(0, 1, 1, 0, 1, 32'hBBBB_0000, 32'h3014, 32'h0,                           32'h3004, 5'd0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h2222_2222, 32'h3008, 32'h2222_2222,                   32'h3008, 5'd0, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 32'h3333_3333, 32'h300C, 32'h3333_3333,                   32'h300C, 5'd0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 1, 1, 32'hCCCC_0000, 32'h3010, 32'h0,                           32'h300C, 5'd0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h4444_4444, 32'h3002, EXC_EN ? 32'h0 : 32'h4444_4444, 32'h3002, fe,   0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h5555_5555, 32'h7000, EXC_EN ? 32'h0 : 32'h5555_5555, 32'h7000, fe,   0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h6666_6666, 32'h6FFC, 32'h6666_6666,                   32'h6FFC, 5'd0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 32'h7777_7777, 32'h2FFC, EXC_EN ? 32'h0 : 32'h7777_7777, 32'h2FFC, fe,   1, 1);
    tbl[14] = mk(1, 1, 0, 0, 1, 32'h9999_9999, 32'h4000, 32'h0,                           32'h3000, 5'd0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 32'h8888_8888, 32'h3010, 32'h8888_8888,                   32'h3010, 5'd0, 0, 1);

    for (int k = 0; k < 16; k++) begin
      apply(tbl[k].rst, tbl[k].stl, tbl[k].cp0, tbl[k].exl, tbl[k].bjd, tbl[k].instr, tbl[k].pc);
      chk($sformatf("vec%0d.InstrD", k),   InstrD,            tbl[k].e_instr);
      chk($sformatf("vec%0d.PcD", k),      PcD,               tbl[k].e_pc);
      chk($sformatf("vec%0d.ExcCodeD", k), {27'h0, ExcCodeD}, {27'h0, tbl[k].e_exc});
      chk($sformatf("vec%0d.BDD", k),      {31'h0, BDD},      {31'h0, tbl[k].e_bd});
      chk($sformatf("vec%0d.ValidD", k),   {31'h0, ValidD},   {31'h0, tbl[k].e_v});
    end

    // Long stall after a delay-slot load: everything must hold every cycle.
    apply(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h5000);
    chk_model("ld_bd");
    for (int k = 0; k < 6; k++) begin
      apply(0, 1, 0, 0, k[0], $urandom, $urandom);
      chk($sformatf("hold%0d.InstrD", k), InstrD, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d.PcD", k), PcD, 32'h5000);
      chk($sformatf("hold%0d.BDD", k), {31'h0, BDD}, 32'h1);
    end
    // Reset together with both flush sources still lands on reset values.
    apply(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h6000);
    chk_model("rst_flush");
    chk("rst_flush.PcD_const", PcD, 32'h3000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: pc_r = 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFC);
        1: pc_r = 32'h3000 + $urandom_range(0, 32'h3FFF);
        2: pc_r = $urandom_range(0, 1) ? 32'h2FFC : 32'h7000;
        default: pc_r = $urandom;
      endcase
      apply($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, $urandom, pc_r);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
